// File: rtl/lfsr_pkg.sv
// ============================================================================
// Module : lfsr_pkg
// Shared FSM encoding, widths and helpers for the LFSR request arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package lfsr_pkg;

  localparam int DWIDTH_DEF    = 8;
  localparam int BUSY_WAIT_MAX = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_RUN       = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_req_arbiter_if.sv
// ============================================================================
// Module : lfsr_req_arbiter_if
// Request and response channels between requesters, arbiter and consumer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface lfsr_req_arbiter_if
  import lfsr_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int IDW    = id_width(NREQ)
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*DWIDTH-1:0] req_taps;
  logic [NREQ*DWIDTH-1:0] req_seq;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [IDW-1:0]         rsp_id;
  logic [DWIDTH-1:0]      rsp_num;
  logic                   rsp_err;

  modport slave (
    input  req_valid, req_taps, req_seq, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_num, rsp_err
  );

  modport master (
    output req_valid, req_taps, req_seq, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_num, rsp_err
  );
endinterface

`default_nettype wire

// File: rtl/lfsr_req_arbiter_rr_picker.sv
// ============================================================================
// Module : lfsr_req_arbiter_rr_picker
// Combinational round-robin: first set request at or after the pointer, wrapping.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lfsr_req_arbiter_rr_picker #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [IDW:0]   sum;
  logic [IDW-1:0] k;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sum   = '0;
    k     = '0;
    for (int i = 0; i < NREQ; i++) begin
      // ptr < NREQ and i < NREQ, so a single subtraction wraps the sum.
      sum = {1'b0, ptr} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      k = sum[IDW-1:0];
      if (!any && req[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        idx      = k;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/lfsr_req_arbiter.sv
// ============================================================================
// Module : lfsr_req_arbiter
// Shares one LFSR engine among NREQ requesters with a single tagged response channel.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lfsr_req_arbiter
  import lfsr_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DWIDTH  = DWIDTH_DEF,
  parameter int TIMEOUT = 300
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  lfsr_req_arbiter_if.slave bus,
  output logic              eng_start,
  output logic [DWIDTH-1:0] eng_sw,
  output logic [DWIDTH-1:0] eng_seq,
  input  logic [DWIDTH-1:0] eng_num,
  input  logic              eng_busy
);

  localparam int IDW = id_width(NREQ);
  localparam int TW  = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [IDW-1:0]    ptr;
  logic [IDW-1:0]    cur_id;
  logic [TW-1:0]     timer;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [DWIDTH-1:0] rsp_num;
  logic              rsp_err;

  logic [NREQ-1:0]   pick_grant;
  logic [IDW-1:0]    pick_idx;
  logic              pick_any;
  logic              grant_en;
  logic [IDW-1:0]    next_ptr;

  logic [DWIDTH-1:0] taps_arr [NREQ];
  logic [DWIDTH-1:0] seq_arr  [NREQ];

  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign taps_arr[k] = bus.req_taps[k*DWIDTH +: DWIDTH];
    assign seq_arr[k]  = bus.req_seq[k*DWIDTH +: DWIDTH];
  end

  lfsr_req_arbiter_rr_picker #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_picker (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Only one transaction may be outstanding: no grant while a response waits.
  assign grant_en      = (state == ST_IDLE) && !rsp_valid;
  assign bus.req_ready = grant_en ? pick_grant : '0;
  assign next_ptr      = (cur_id == IDW'(NREQ - 1)) ? '0 : cur_id + 1'b1;

  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_id    = rsp_id;
  assign bus.rsp_num   = rsp_num;
  assign bus.rsp_err   = rsp_err;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      cur_id    <= '0;
      timer     <= '0;
      eng_start <= 1'b0;
      eng_sw    <= '0;
      eng_seq   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_num   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      if (rsp_valid && bus.rsp_ready) begin
        rsp_valid <= 1'b0;
        rsp_id    <= '0;
        rsp_num   <= '0;
        rsp_err   <= 1'b0;
      end
      unique case (state)
        ST_IDLE: begin
          if (grant_en && pick_any) begin
            cur_id    <= pick_idx;
            eng_sw    <= taps_arr[pick_idx];
            eng_seq   <= seq_arr[pick_idx];
            eng_start <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          timer <= '0;
          state <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (eng_busy) begin
            timer <= '0;
            state <= ST_RUN;
          end else if (timer == TW'(BUSY_WAIT_MAX - 1)) begin
            rsp_valid <= 1'b1;
            rsp_id    <= cur_id;
            rsp_num   <= '0;
            rsp_err   <= 1'b1;
            state     <= ST_DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_RUN: begin
          // The response is loaded on the way into DONE so it is visible in DONE.
          if (!eng_busy) begin
            rsp_valid <= 1'b1;
            rsp_id    <= cur_id;
            rsp_num   <= eng_num;
            rsp_err   <= 1'b0;
            state     <= ST_DONE;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            rsp_valid <= 1'b1;
            rsp_id    <= cur_id;
            rsp_num   <= '0;
            rsp_err   <= 1'b1;
            state     <= ST_DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_DONE: begin
          ptr   <= next_ptr;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lfsr_req_arbiter.sv
// ============================================================================
// Module : tb_lfsr_req_arbiter
// Scoreboard bench for lfsr_req_arbiter with a behavioural engine model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lfsr_req_arbiter;

  localparam int NREQ    = 4;
  localparam int DWIDTH  = 8;
  localparam int TIMEOUT = 300;
  localparam int IDW     = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lfsr_req_arbiter_if #(.NREQ(NREQ), .DWIDTH(DWIDTH), .IDW(IDW)) bus ();

  logic              eng_start;
  logic              eng_busy;
  logic [DWIDTH-1:0] eng_sw;
  logic [DWIDTH-1:0] eng_seq;
  logic [DWIDTH-1:0] eng_num;

  lfsr_req_arbiter #(
    .NREQ    (NREQ),
    .DWIDTH  (DWIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .bus       (bus),
    .eng_start (eng_start),
    .eng_sw    (eng_sw),
    .eng_seq   (eng_seq),
    .eng_num   (eng_num),
    .eng_busy  (eng_busy)
  );

  // Engine model: mode 0 busy for eng_dur cycles, 1 never busy, 2 stuck busy.
  int   eng_mode  = 0;
  int   eng_dur   = 7;
  int   busy_left = 0;
  logic glitch    = 1'b0;

  function automatic logic [7:0] eng_fn(input logic [7:0] sw, input logic [7:0] sq);
    return {sw[3:0], sq[3:0]} ^ 8'h1F;
  endfunction

  always @(posedge clk) begin
    if (rst)                           busy_left <= 0;
    else if (eng_start && eng_mode==0) busy_left <= eng_dur;
    else if (eng_start && eng_mode==2) busy_left <= 1000000;
    else if (busy_left > 0)            busy_left <= busy_left - 1;
  end
  assign eng_busy = (busy_left > 0) || glitch;
  assign eng_num  = eng_fn(eng_sw, eng_seq);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [IDW-1:0] id;
    logic [7:0]     num;
    logic           err;
    int             lat;
    int             gcyc;
  } exp_t;

  exp_t sb[$];
  int   grant_ids[$];
  int   cyc = 0;
  int   n_grant = 0, n_start = 0, n_acc = 0, n_rise = 0;
  int   last_grant_id = -1, last_grant_cyc = 0, last_acc_cyc = 0;
  logic [7:0] last_num = '0;
  logic prev_rsp = 1'b0, prev_start = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      prev_rsp   = 1'b0;
      prev_start = 1'b0;
    end else begin
      if (bus.req_ready != '0) begin
        check_eq("req_ready_onehot", $countones(bus.req_ready), 1);
        for (int k = 0; k < NREQ; k++) begin
          if (bus.req_ready[k] && bus.req_valid[k]) begin
            exp_t e;
            e.id   = IDW'(k);
            e.err  = (eng_mode != 0);
            e.num  = (eng_mode == 0) ? eng_fn(bus.req_taps[k*8 +: 8], bus.req_seq[k*8 +: 8]) : 8'h00;
            e.lat  = (eng_mode == 0) ? eng_dur + 3 : (eng_mode == 1) ? 6 : TIMEOUT + 3;
            e.gcyc = cyc;
            sb.push_back(e);
            grant_ids.push_back(k);
            n_grant++;
            last_grant_id  = k;
            last_grant_cyc = cyc;
          end
        end
      end
      if (eng_start) begin
        n_start++;
        if (prev_start) check_eq("eng_start_width", 32'd2, 32'd1);
      end
      prev_start = eng_start;
      if (bus.rsp_valid && !prev_rsp) begin
        n_rise++;
        if (sb.size() == 0) check_eq("unexpected_rsp", bus.rsp_valid, 1'b0);
        else check_eq("latency", cyc - sb[0].gcyc, sb[0].lat);
      end
      prev_rsp = bus.rsp_valid;
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_accept", bus.rsp_valid, 1'b0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("rsp_id",  bus.rsp_id,  e.id);
          check_eq("rsp_num", bus.rsp_num, e.num);
          check_eq("rsp_err", bus.rsp_err, e.err);
        end
        n_acc++;
        last_acc_cyc = cyc;
        last_num     = bus.rsp_num;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(input int k, input logic [7:0] taps, input logic [7:0] sq);
    bus.req_taps[k*8 +: 8] = taps;
    bus.req_seq[k*8 +: 8]  = sq;
  endtask

  task automatic wait_grant(input string tag, input int target, input int bound);
    int t;
    t = 0;
    while (n_grant < target && t < bound) begin
      tick(1);
      t++;
    end
    check_eq(tag, n_grant >= target, 1'b1);
  endtask

  task automatic wait_empty(input string tag, input int bound);
    int t;
    t = 0;
    while (sb.size() != 0 && t < bound) begin
      tick(1);
      t++;
    end
    check_eq(tag, sb.size(), 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    int g0, s0, a0, r0, t;
    logic [IDW-1:0] h_id;
    logic [7:0]     h_num;
    logic           h_err, stable;

    bus.req_valid = '0;
    bus.req_taps  = '0;
    bus.req_seq   = '0;
    bus.rsp_ready = 1'b0;
    tick(3);
    check_eq("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check_eq("rst_rsp_id",    bus.rsp_id,    '0);
    check_eq("rst_rsp_num",   bus.rsp_num,   '0);
    check_eq("rst_rsp_err",   bus.rsp_err,   1'b0);
    check_eq("rst_eng_start", eng_start,     1'b0);
    check_eq("rst_eng_sw",    eng_sw,        '0);
    check_eq("rst_eng_seq",   eng_seq,       '0);
    rst = 1'b0;
    tick(1);

    // Fairness: all four requesters pending continuously.
    for (int k = 0; k < NREQ; k++) set_req(k, 8'(8'h10 + k), 8'(k + 1));
    eng_mode = 0; eng_dur = 3;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'hF;
    wait_grant("fair_grants", 6, 200);
    bus.req_valid = '0;
    wait_empty("fair_drain", 50);
    for (int i = 0; i < 6; i++)
      check_eq("fair_order", (i < grant_ids.size()) ? grant_ids[i] : -1, i % NREQ);

    // Single request from requester 2.
    eng_dur = 7;
    set_req(2, 8'h03, 8'd5);
    g0 = n_grant; s0 = n_start;
    bus.req_valid = 4'b0100;
    wait_grant("t1_grant", g0 + 1, 20);
    bus.req_valid = '0;
    wait_empty("t1_drain", 40);
    check_eq("t1_grant_cnt", n_grant - g0, 1);
    check_eq("t1_start_cnt", n_start - s0, 1);
    check_eq("t1_num",       last_num, 8'h2A);

    // Busy glitch while idle must not start anything.
    s0 = n_start;
    glitch = 1'b1;
    tick(3);
    glitch = 1'b0;
    tick(2);
    check_eq("glitch_start", n_start - s0, 0);
    check_eq("glitch_rsp",   bus.rsp_valid, 1'b0);

    // Backpressure with a single, always-pending requester.
    eng_dur = 4;
    set_req(0, 8'h5A, 8'h33);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0001;
    t = 0;
    while (!bus.rsp_valid && t < 50) begin tick(1); t++; end
    check_eq("bp_rsp_seen", bus.rsp_valid, 1'b1);
    h_id = bus.rsp_id; h_num = bus.rsp_num; h_err = bus.rsp_err;
    g0 = n_grant; s0 = n_start; a0 = n_acc;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (!bus.rsp_valid || bus.rsp_id !== h_id || bus.rsp_num !== h_num || bus.rsp_err !== h_err)
        stable = 1'b0;
    end
    check_eq("bp_stable", stable, 1'b1);
    check_eq("bp_no_grant", n_grant - g0, 0);
    check_eq("bp_no_start", n_start - s0, 0);
    bus.rsp_ready = 1'b1;
    wait_grant("bp_regrant", g0 + 1, 10);
    bus.req_valid = '0;
    check_eq("bp_one_accept",  n_acc - a0, 1);
    check_eq("bp_grant_delay", last_grant_cyc - last_acc_cyc, 1);
    check_eq("bp_regrant_id",  last_grant_id, 0);
    wait_empty("bp_drain", 40);

    // Engine stuck busy -> RUN timeout.
    eng_mode = 2;
    set_req(1, 8'h77, 8'h11);
    g0 = n_grant;
    bus.req_valid = 4'b0010;
    wait_grant("to_run_grant", g0 + 1, 20);
    bus.req_valid = '0;
    wait_empty("to_run_drain", TIMEOUT + 40);
    pulse_reset();

    // Engine never raises busy -> WAIT_BUSY timeout.
    eng_mode = 1;
    g0 = n_grant;
    bus.req_valid = 4'b0001;
    wait_grant("to_wait_grant", g0 + 1, 20);
    bus.req_valid = '0;
    wait_empty("to_wait_drain", 40);

    // Reset in the middle of RUN.
    eng_mode = 0; eng_dur = 50;
    set_req(2, 8'h12, 8'h34);
    g0 = n_grant;
    bus.req_valid = 4'b0100;
    wait_grant("mid_grant", g0 + 1, 20);
    bus.req_valid = '0;
    tick(10);
    rst = 1'b1;
    tick(1);
    check_eq("mid_rsp_valid", bus.rsp_valid, 1'b0);
    check_eq("mid_eng_start", eng_start,     1'b0);
    check_eq("mid_eng_sw",    eng_sw,        '0);
    check_eq("mid_eng_seq",   eng_seq,       '0);
    check_eq("mid_rsp_num",   bus.rsp_num,   '0);
    sb.delete();
    rst = 1'b0;
    r0 = n_rise;
    tick(60);
    check_eq("mid_no_rsp", n_rise - r0, 0);
    // Pointer back at 0: of requesters 1 and 3, 1 wins.
    eng_dur = 2;
    set_req(1, 8'hA1, 8'hB2);
    set_req(3, 8'hC3, 8'hD4);
    g0 = n_grant;
    bus.req_valid = 4'b1010;
    wait_grant("ptr_grant", g0 + 1, 10);
    check_eq("ptr_zero_id", last_grant_id, 1);
    bus.req_valid = 4'b1000;
    wait_grant("r3_grant", g0 + 2, 40);
    bus.req_valid = '0;
    check_eq("r3_id", last_grant_id, 3);
    wait_empty("r3_drain", 40);

    // Operand changes after grant are ignored.
    eng_dur = 10;
    set_req(1, 8'h4C, 8'h21);
    g0 = n_grant;
    bus.req_valid = 4'b0010;
    wait_grant("hold_grant", g0 + 1, 20);
    bus.req_valid = '0;
    set_req(1, 8'hFF, 8'hEE);
    tick(5);
    check_eq("hold_sw",  eng_sw,  8'h4C);
    check_eq("hold_seq", eng_seq, 8'h21);
    wait_empty("hold_drain", 40);

    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
